// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL supervisor: RESETB pulse, filtered lock wait with retry, staggered domain reset release
module pll_reset_sequencer #(
  parameter int NUM_OUTPUTS      = 2,
  parameter int SYNC_STAGES      = 2,
  parameter int PLL_RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT     = 65535,
  parameter int LOCK_FILTER      = 256,
  parameter int STAGE_DELAY      = 64,
  parameter int COUNT_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   soft_reset,
  output logic                   pll_resetb,
  output logic [NUM_OUTPUTS-1:0] domain_reset,
  output logic                   all_released,
  output logic [COUNT_WIDTH-1:0] lock_loss_count,
  output logic [COUNT_WIDTH-1:0] timeout_count,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  localparam int REL_SPAN = NUM_OUTPUTS * STAGE_DELAY;
  localparam int MAX_A    = (LOCK_TIMEOUT > LOCK_FILTER) ? LOCK_TIMEOUT : LOCK_FILTER;
  localparam int MAX_B    = (REL_SPAN > PLL_RESET_CYCLES) ? REL_SPAN : PLL_RESET_CYCLES;
  localparam int CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] FLT_LAST = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_SPAN - 1);

  state_t                 st;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   lock_lost;

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign lock_lost = ((st == S_RELEASE) || (st == S_RUN)) && !lock_s;
  assign state     = st;

  always_ff @(posedge clk) begin
    if (reset) begin
      st              <= S_PLL_RESET;
      cnt             <= '0;
      pll_resetb      <= 1'b0;
      domain_reset    <= '1;
      all_released    <= 1'b0;
      lock_loss_count <= '0;
      timeout_count   <= '0;
      sync_q          <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      // Soft reset outranks lock loss, so only a genuine loss is counted.
      if (soft_reset || lock_lost) begin
        st           <= S_PLL_RESET;
        cnt          <= '0;
        pll_resetb   <= 1'b0;
        domain_reset <= '1;
        all_released <= 1'b0;
        if (!soft_reset && (lock_loss_count != '1))
          lock_loss_count <= lock_loss_count + 1'b1;
      end else begin
        case (st)
          S_PLL_RESET: begin
            if (cnt == RST_LAST) begin
              st         <= S_WAIT_LOCK;
              cnt        <= '0;
              pll_resetb <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (lock_s) begin
              st  <= S_FILTER;
              cnt <= '0;
            end else if (cnt == TMO_LAST) begin
              st         <= S_PLL_RESET;
              cnt        <= '0;
              pll_resetb <= 1'b0;
              if (timeout_count != '1)
                timeout_count <= timeout_count + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_FILTER: begin
            if (!lock_s) begin
              st  <= S_WAIT_LOCK;
              cnt <= '0;
            end else if (cnt == FLT_LAST) begin
              st  <= S_RELEASE;
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            for (int i = 0; i < NUM_OUTPUTS; i++) begin
              if (cnt == CNT_W'(STAGE_DELAY * (i + 1) - 1))
                domain_reset[i] <= 1'b0;
            end
            if (cnt == REL_LAST) begin
              st           <= S_RUN;
              cnt          <= '0;
              all_released <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RUN: begin
          end
          default: begin
            st           <= S_PLL_RESET;
            cnt          <= '0;
            pll_resetb   <= 1'b0;
            domain_reset <= '1;
            all_released <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed and random checks of pll_reset_sequencer against a phase/elapsed-time model
module tb_pll_reset_sequencer;

  localparam int N   = 2;
  localparam int SS  = 2;
  localparam int PRC = 4;
  localparam int LT  = 32;
  localparam int LF  = 8;
  localparam int SD  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pll_locked = 1'b0;
  logic          soft_reset = 1'b0;
  logic          pll_resetb;
  logic [N-1:0]  domain_reset;
  logic          all_released;
  logic [CW-1:0] lock_loss_count;
  logic [CW-1:0] timeout_count;
  logic [2:0]    state;

  pll_reset_sequencer #(
    .NUM_OUTPUTS(N), .SYNC_STAGES(SS), .PLL_RESET_CYCLES(PRC), .LOCK_TIMEOUT(LT),
    .LOCK_FILTER(LF), .STAGE_DELAY(SD), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked), .soft_reset(soft_reset),
    .pll_resetb(pll_resetb), .domain_reset(domain_reset), .all_released(all_released),
    .lock_loss_count(lock_loss_count), .timeout_count(timeout_count), .state(state)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: phase number, cycles spent in it, and a delay line for the lock synchroniser.
  int m_phase   = 0;
  int m_elapsed = 0;
  int m_loss    = 0;
  int m_tmo     = 0;
  bit m_hist[$];

  function automatic int sat_inc(int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  function automatic void enter(int p);
    m_phase   = p;
    m_elapsed = 0;
  endfunction

  function automatic logic [N-1:0] exp_dom();
    logic [N-1:0] d;
    for (int i = 0; i < N; i++)
      d[i] = (m_phase < 3) || ((m_phase == 3) && (m_elapsed < SD * (i + 1)));
    return d;
  endfunction

  task automatic model_edge();
    bit ls;
    ls = m_hist.pop_front();
    m_hist.push_back(pll_locked);
    if (reset) begin
      m_hist.delete();
      repeat (SS) m_hist.push_back(1'b0);
      enter(0);
      m_loss = 0;
      m_tmo  = 0;
    end else if (soft_reset) begin
      enter(0);
    end else if (m_phase >= 3 && !ls) begin
      enter(0);
      m_loss = sat_inc(m_loss);
    end else begin
      case (m_phase)
        0: if (m_elapsed == PRC - 1) enter(1); else m_elapsed++;
        1: if (ls) enter(2);
           else if (m_elapsed == LT - 1) begin enter(0); m_tmo = sat_inc(m_tmo); end
           else m_elapsed++;
        2: if (!ls) enter(1); else if (m_elapsed == LF - 1) enter(3); else m_elapsed++;
        3: if (m_elapsed == N * SD - 1) enter(4); else m_elapsed++;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", {29'd0, state}, m_phase);
    chk("pll_resetb", {31'd0, pll_resetb}, (m_phase != 0) ? 1 : 0);
    chk("domain_reset", {30'd0, domain_reset}, {30'd0, exp_dom()});
    chk("all_released", {31'd0, all_released}, (m_phase == 4) ? 1 : 0);
    chk("lock_loss_count", {28'd0, lock_loss_count}, m_loss);
    chk("timeout_count", {28'd0, timeout_count}, m_tmo);
  endtask

  task automatic wait_state(input logic [2:0] s, input int limit, output int n);
    n = 0;
    while (state !== s && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int run_left;
    logic [CW-1:0] tmo_saved;
    repeat (SS) m_hist.push_back(1'b0);

    // Bring-up with lock already present
    reset = 1'b1; pll_locked = 1'b1;
    repeat (3) tick();
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_domain", {30'd0, domain_reset}, 3);
    reset = 1'b0;
    n = 0;
    while (pll_resetb !== 1'b1 && n < 50) begin tick(); n++; end
    chk("s1_resetb_low_cycles", n, PRC);
    wait_state(3'd2, 50, n);
    wait_state(3'd3, 50, n);
    chk("s1_filter_cycles", n, LF);
    n = 0;
    while (domain_reset[0] !== 1'b0 && n < 50) begin tick(); n++; end
    chk("s1_dom0_delay", n, SD);
    chk("s1_dom1_still_set", {31'd0, domain_reset[1]}, 1);
    n = 0;
    while (domain_reset[1] !== 1'b0 && n < 50) begin tick(); n++; end
    chk("s1_dom1_delay", n, SD);
    chk("s1_all_released", {31'd0, all_released}, 1);
    chk("s1_run", {29'd0, state}, 4);

    // Timeout with no lock, up to saturation
    pll_locked = 1'b0; reset = 1'b1; tick(); reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      wait_state(3'd1, 100, n);
      chk("s2_low_time", n, PRC);
      wait_state(3'd0, 100, n);
      chk("s2_high_time", n, LT);
      chk("s2_timeouts", {28'd0, timeout_count}, (k > SAT) ? SAT : k);
    end

    // One-cycle dropout in the middle of FILTER
    pll_locked = 1'b1; reset = 1'b1; tick(); reset = 1'b0;
    wait_state(3'd2, 100, n);
    repeat (3) tick();
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    wait_state(3'd1, 6, n);
    chk("s3_back_to_wait", {29'd0, state}, 1);
    chk("s3_loss_unchanged", {28'd0, lock_loss_count}, 0);
    chk("s3_domain_held", {30'd0, domain_reset}, 3);
    wait_state(3'd4, 100, n);
    chk("s3_reaches_run", {29'd0, state}, 4);

    // Lock loss while running
    pll_locked = 1'b0;
    wait_state(3'd0, 20, n);
    chk("s4_loss_latency", n, SS + 1);
    chk("s4_domain", {30'd0, domain_reset}, 3);
    chk("s4_all_released", {31'd0, all_released}, 0);
    chk("s4_loss_count", {28'd0, lock_loss_count}, 1);
    pll_locked = 1'b1;
    wait_state(3'd4, 100, n);
    chk("s4_rerun", {29'd0, state}, 4);

    // Lock loss after partial release, then soft reset while running
    soft_reset = 1'b1; tick(); soft_reset = 1'b0;
    n = 0;
    while (domain_reset !== 2'b10 && n < 100) begin tick(); n++; end
    pll_locked = 1'b0;
    n = 0;
    while (domain_reset !== 2'b11 && n < 20) begin tick(); n++; end
    chk("s5_partial_latency", n, SS + 1);
    chk("s5_loss_count", {28'd0, lock_loss_count}, 2);
    pll_locked = 1'b1;
    wait_state(3'd4, 100, n);
    tmo_saved = timeout_count;
    soft_reset = 1'b1; tick();
    chk("s5_soft_state", {29'd0, state}, 0);
    chk("s5_soft_domain", {30'd0, domain_reset}, 3);
    chk("s5_soft_loss", {28'd0, lock_loss_count}, 2);
    chk("s5_soft_tmo", {28'd0, timeout_count}, {28'd0, tmo_saved});
    repeat (5) tick();
    soft_reset = 1'b0;
    wait_state(3'd1, 50, n);
    chk("s5_restart_low_time", n, PRC);

    // Reset in the middle of RELEASE
    wait_state(3'd3, 100, n);
    repeat (2) tick();
    reset = 1'b1; tick();
    chk("s6_state", {29'd0, state}, 0);
    chk("s6_resetb", {31'd0, pll_resetb}, 0);
    chk("s6_domain", {30'd0, domain_reset}, 3);
    chk("s6_all_released", {31'd0, all_released}, 0);
    chk("s6_loss", {28'd0, lock_loss_count}, 0);
    chk("s6_tmo", {28'd0, timeout_count}, 0);
    reset = 1'b0;

    // Random lock runs with occasional soft and hard resets
    run_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (run_left == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        run_left = pll_locked ? $urandom_range(1, 60) : $urandom_range(1, 12);
      end
      run_left--;
      soft_reset = ($urandom_range(0, 149) == 0);
      reset      = ($urandom_range(0, 799) == 0);
      tick();
    end
    reset = 1'b0; soft_reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
